// File: rtl/brownout_recovery_ctrl.sv
// Brownout response sequencer: requests a context save, holds the system in reset,
// and releases only after the supply has qualified good for H_eff+1 consecutive samples.
module brownout_recovery_ctrl #(
  parameter int SAVE_TIMEOUT = 1024,
  parameter int EVT_W        = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BROWNOUT,
  input  logic [19:0]      ADC_IN,
  input  logic [19:0]      RECOVER_THRESH,
  input  logic [15:0]      HOLD_CYCLES,
  input  logic             SAVE_ACK,
  output logic             SAVE_REQ,
  output logic             SYS_HOLD,
  output logic             SAVE_FAIL,
  output logic [1:0]       STATE,
  output logic [EVT_W-1:0] EVENT_COUNT
);

  localparam int DATA_W = 20;
  localparam logic [15:0] TMO_LAST = 16'(SAVE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SAVE    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      save_tmr_q, save_tmr_d;
  logic [15:0]      qual_q, qual_d;
  logic             save_fail_q, save_fail_d;
  logic [EVT_W-1:0] evt_q, evt_d;

  logic             good;
  logic [15:0]      h_eff;
  logic [16:0]      qual_inc;
  logic             qual_done;

  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == {EVT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign good      = !BROWNOUT && (ADC_IN >= RECOVER_THRESH[DATA_W-1:0]);
  assign h_eff     = (HOLD_CYCLES == 16'd0) ? 16'd1 : HOLD_CYCLES;
  assign qual_inc  = {1'b0, qual_q} + 17'd1;
  assign qual_done = qual_inc >= {1'b0, h_eff};

  always_comb begin
    state_d     = state_q;
    save_tmr_d  = save_tmr_q;
    qual_d      = qual_q;
    save_fail_d = save_fail_q;
    evt_d       = evt_q;
    unique case (state_q)
      ST_RUN: begin
        if (BROWNOUT) begin
          state_d    = ST_SAVE;
          save_tmr_d = 16'd0;
          evt_d      = sat_inc(evt_q);
        end
      end
      ST_SAVE: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (SAVE_ACK) begin
          state_d = ST_HOLD;
        end else if (save_tmr_q == TMO_LAST) begin
          state_d     = ST_HOLD;
          save_fail_d = 1'b1;
        end else begin
          save_tmr_d = save_tmr_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (good) begin
          state_d = ST_RECOVER;
          qual_d  = 16'd0;
        end
      end
      ST_RECOVER: begin
        if (!good) begin
          state_d = ST_HOLD;
        end else if (qual_done) begin
          state_d = ST_RUN;
        end else begin
          qual_d = qual_inc[15:0];
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      save_tmr_q  <= 16'd0;
      qual_q      <= 16'd0;
      save_fail_q <= 1'b0;
      evt_q       <= '0;
    end else begin
      state_q     <= state_d;
      save_tmr_q  <= save_tmr_d;
      qual_q      <= qual_d;
      save_fail_q <= save_fail_d;
      evt_q       <= evt_d;
    end
  end

  assign SAVE_REQ    = (state_q == ST_SAVE);
  assign SYS_HOLD    = (state_q == ST_HOLD) || (state_q == ST_RECOVER);
  assign SAVE_FAIL   = save_fail_q;
  assign STATE       = state_q;
  assign EVENT_COUNT = evt_q;

endmodule

// File: tb/tb_brownout_recovery_ctrl.sv
// Directed bench for brownout_recovery_ctrl: save/ack, timeout, qualification,
// reset abort and event-counter saturation, with hand-computed expectations.
module tb_brownout_recovery_ctrl;

  logic        CLK;
  logic        RST;
  logic        BROWNOUT;
  logic [19:0] ADC_IN;
  logic [19:0] RECOVER_THRESH;
  logic [15:0] HOLD_CYCLES;
  logic        SAVE_ACK;
  logic        SAVE_REQ;
  logic        SYS_HOLD;
  logic        SAVE_FAIL;
  logic [1:0]  STATE;
  logic [7:0]  EVENT_COUNT;

  int n_vec  = 0;
  int n_miss = 0;
  int n;

  brownout_recovery_ctrl #(
    .SAVE_TIMEOUT(16),
    .EVT_W       (8)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .BROWNOUT      (BROWNOUT),
    .ADC_IN        (ADC_IN),
    .RECOVER_THRESH(RECOVER_THRESH),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .SAVE_ACK      (SAVE_ACK),
    .SAVE_REQ      (SAVE_REQ),
    .SYS_HOLD      (SYS_HOLD),
    .SAVE_FAIL     (SAVE_FAIL),
    .STATE         (STATE),
    .EVENT_COUNT   (EVENT_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int st, input int req, input int hold,
                            input int fail, input int ev);
    check_val({tag, ".state"},     32'(STATE),       32'(st));
    check_val({tag, ".save_req"},  32'(SAVE_REQ),    32'(req));
    check_val({tag, ".sys_hold"},  32'(SYS_HOLD),    32'(hold));
    check_val({tag, ".save_fail"}, 32'(SAVE_FAIL),   32'(fail));
    check_val({tag, ".evt"},       32'(EVENT_COUNT), 32'(ev));
  endtask

  // Counts edges until the block is back in RUN; bounded so a stuck DUT still ends.
  task automatic run_until_run(output int cnt);
    cnt = 0;
    while (STATE != 2'd0 && cnt < 64) begin
      tick();
      cnt++;
    end
  endtask

  task automatic save_with_ack();
    BROWNOUT = 1'b1;
    tick();
    BROWNOUT = 1'b0;
    SAVE_ACK = 1'b1;
    tick();
    SAVE_ACK = 1'b0;
  endtask

  initial begin
    RST = 1'b1; BROWNOUT = 1'b0; ADC_IN = 20'h0; RECOVER_THRESH = 20'h80000;
    HOLD_CYCLES = 16'd8; SAVE_ACK = 1'b0;
    tick(); tick();
    RST = 1'b0;
    expect_out("reset", 0, 0, 0, 0, 0);
    repeat (20) tick();
    expect_out("idle", 0, 0, 0, 0, 0);

    // Brownout, ack three cycles later
    BROWNOUT = 1'b1;
    tick();
    BROWNOUT = 1'b0;
    expect_out("bo_entry", 1, 1, 0, 0, 1);
    tick();
    check_val("save_req_c2", 32'(SAVE_REQ), 32'd1);
    tick();
    check_val("save_req_c3", 32'(SAVE_REQ), 32'd1);
    SAVE_ACK = 1'b1;
    tick();
    SAVE_ACK = 1'b0;
    expect_out("ack", 2, 0, 1, 0, 1);

    // Threshold-exact supply, H=8: release 8 edges after first good edge
    ADC_IN = 20'h80000;
    run_until_run(n);
    check_val("rel_h8_edges", 32'(n), 32'd9);
    check_val("rel_h8_hold", 32'(SYS_HOLD), 32'd0);

    // Dip at qualify count 5 restarts qualification
    ADC_IN = 20'h0;
    save_with_ack();
    expect_out("dip_hold", 2, 0, 1, 0, 2);
    ADC_IN = 20'h80000;
    repeat (6) tick();
    check_val("dip_pre_state", 32'(STATE), 32'd3);
    ADC_IN = 20'h7FFFF;
    tick();
    check_val("dip_state", 32'(STATE), 32'd2);
    ADC_IN = 20'h80000;
    run_until_run(n);
    check_val("dip_rel_edges", 32'(n), 32'd9);

    // Timeout with no ack
    ADC_IN = 20'h0;
    BROWNOUT = 1'b1;
    tick();
    BROWNOUT = 1'b0;
    n = 0;
    while (SAVE_REQ && n < 100) begin
      n++;
      tick();
    end
    check_val("tmo_req_cycles", 32'(n), 32'd16);
    expect_out("tmo", 2, 0, 1, 1, 3);
    ADC_IN = 20'hFFFFF;
    run_until_run(n);
    check_val("tmo_rel_edges", 32'(n), 32'd9);
    ADC_IN = 20'h0;
    save_with_ack();
    expect_out("ack_after_tmo", 2, 0, 1, 1, 4);

    // HOLD_CYCLES = 0 behaves as 1
    HOLD_CYCLES = 16'd0;
    ADC_IN = 20'h80001;
    tick();
    check_val("h0_rec", 32'(STATE), 32'd3);
    tick();
    check_val("h0_run", 32'(STATE), 32'd0);
    check_val("h0_hold", 32'(SYS_HOLD), 32'd0);

    // Brownout on the first RUN cycle after recovery
    BROWNOUT = 1'b1;
    tick();
    expect_out("bo_first_run", 1, 1, 0, 1, 5);
    BROWNOUT = 1'b0;
    SAVE_ACK = 1'b1;
    tick();
    SAVE_ACK = 1'b0;

    // Brownout on the edge that would exit RECOVER
    HOLD_CYCLES = 16'd1;
    tick();
    check_val("bx_rec", 32'(STATE), 32'd3);
    BROWNOUT = 1'b1;
    tick();
    BROWNOUT = 1'b0;
    check_val("bo_on_exit", 32'(STATE), 32'd2);

    // Reset in RECOVER
    HOLD_CYCLES = 16'd8;
    tick();
    check_val("rst_pre", 32'(STATE), 32'd3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    expect_out("rst_in_rec", 0, 0, 0, 0, 0);

    // Ack on the timeout edge wins
    ADC_IN = 20'h0;
    BROWNOUT = 1'b1;
    tick();
    BROWNOUT = 1'b0;
    repeat (15) tick();
    check_val("ack_tmo_pre", 32'(SAVE_REQ), 32'd1);
    SAVE_ACK = 1'b1;
    tick();
    SAVE_ACK = 1'b0;
    expect_out("ack_at_tmo", 2, 0, 1, 0, 1);
    HOLD_CYCLES = 16'd1;
    ADC_IN = 20'h80000;
    run_until_run(n);
    check_val("ack_tmo_rel", 32'(n), 32'd2);

    // Event counter saturation
    for (int i = 0; i < 300; i++) begin
      save_with_ack();
      run_until_run(n);
      if (i == 253) check_val("evt_reach_max", 32'(EVENT_COUNT), 32'd255);
    end
    check_val("evt_saturated", 32'(EVENT_COUNT), 32'd255);
    check_val("evt_state", 32'(STATE), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
